// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its data-memory request FSM.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer: captures a load/store, holds req until ack or timeout,
// and produces the upstream stall and bus-error pulse.
module dmem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              req_o,
    output logic              we_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              cap_reg_write_o,
    output logic              cap_mem_to_reg_o,
    output logic [REG_W-1:0]  cap_rd_o,
    output logic              bus_err_o
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [REG_W-1:0]  rd_q, rd_d;

    logic memop_s;
    logic busy_s;
    logic timeout_s;

    assign memop_s   = valid_i & (mem_read_i | mem_write_i);
    assign busy_s    = (state_q == ST_BUSY);
    assign timeout_s = busy_s & ~ack_i & (cnt_q == CNT_MAX);

    // Next-state, timeout counter and request capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (memop_s) begin
                    state_d      = ST_BUSY;
                    cnt_d        = '0;
                    we_d         = mem_write_i;
                    addr_d       = addr_i;
                    wdata_d      = wdata_i;
                    reg_write_d  = reg_write_i;
                    mem_to_reg_d = mem_to_reg_i;
                    rd_d         = rd_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // ack takes priority over a coincident timeout
                if (ack_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (timeout_s) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and captured request registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
        end
    end

    assign busy_o           = busy_s;
    assign done_o           = busy_s & ack_i;
    assign stall_o          = ~rst_i & (busy_s ? (~ack_i & ~timeout_s) : memop_s);
    assign req_o            = busy_s;
    assign we_o             = we_q;
    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign cap_reg_write_o  = reg_write_q;
    assign cap_mem_to_reg_o = mem_to_reg_q;
    assign cap_rd_o         = rd_q;
    assign bus_err_o        = bus_err_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch/jump redirect, data-memory access via dmem_req_fsm,
// and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iValid,
    input  logic              iRegWrite,
    input  logic              iMemToReg,
    input  logic              iMemWrite,
    input  logic              iMemRead,
    input  logic              iMemBranch,
    input  logic              ijump,
    input  logic [DATA_W-1:0] iAdderSL2Result,
    input  logic              iZFlag,
    input  logic [DATA_W-1:0] iAluRes,
    input  logic [DATA_W-1:0] iData2,
    input  logic [REG_W-1:0]  iRegDestMux,
    output logic              oDmemReq,
    output logic              oDmemWe,
    output logic [DATA_W-1:0] oDmemAddr,
    output logic [DATA_W-1:0] oDmemWData,
    input  logic              iDmemAck,
    input  logic [DATA_W-1:0] iDmemRData,
    output logic              oStall,
    output logic              oPCSrc,
    output logic [DATA_W-1:0] oBranchTarget,
    output logic              oBusErr,
    output logic              oValid,
    output logic              oRegWrite,
    output logic              oMemToReg,
    output logic [DATA_W-1:0] oReadData,
    output logic [DATA_W-1:0] oAluRes,
    output logic [REG_W-1:0]  oRegDestMux
);

    logic              fsm_busy_s;
    logic              fsm_done_s;
    logic              cap_reg_write_s;
    logic              cap_mem_to_reg_s;
    logic [REG_W-1:0]  cap_rd_s;
    logic              memop_s;

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d;
    logic [REG_W-1:0]  rd_q, rd_d;

    dmem_req_fsm #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk_i            (clk),
        .rst_i            (reset),
        .valid_i          (iValid),
        .mem_read_i       (iMemRead),
        .mem_write_i      (iMemWrite),
        .reg_write_i      (iRegWrite),
        .mem_to_reg_i     (iMemToReg),
        .addr_i           (iAluRes),
        .wdata_i          (iData2),
        .rd_i             (iRegDestMux),
        .ack_i            (iDmemAck),
        .busy_o           (fsm_busy_s),
        .done_o           (fsm_done_s),
        .stall_o          (oStall),
        .req_o            (oDmemReq),
        .we_o             (oDmemWe),
        .addr_o           (oDmemAddr),
        .wdata_o          (oDmemWData),
        .cap_reg_write_o  (cap_reg_write_s),
        .cap_mem_to_reg_o (cap_mem_to_reg_s),
        .cap_rd_o         (cap_rd_s),
        .bus_err_o        (oBusErr)
    );

    assign memop_s = iMemRead | iMemWrite;

    // MEM/WB next value: completed memop, pass-through ALU op, or bubble
    always_comb begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        read_data_d  = '0;
        alu_res_d    = '0;
        rd_d         = '0;
        if (fsm_done_s) begin
            valid_d      = 1'b1;
            reg_write_d  = cap_reg_write_s;
            mem_to_reg_d = cap_mem_to_reg_s;
            read_data_d  = oDmemWe ? '0 : iDmemRData;
            alu_res_d    = oDmemAddr;
            rd_d         = cap_rd_s;
        end else if (!fsm_busy_s && iValid && !memop_s) begin
            valid_d      = 1'b1;
            reg_write_d  = iRegWrite;
            mem_to_reg_d = iMemToReg;
            alu_res_d    = iAluRes;
            rd_d         = iRegDestMux;
        end else begin
            valid_d = 1'b0;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_res_q    <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_res_q    <= alu_res_d;
            rd_q         <= rd_d;
        end
    end

    // Redirect only from IDLE and never while stalling upstream
    assign oPCSrc = ~reset & ~fsm_busy_s & ~oStall & iValid & ((iMemBranch & iZFlag) | ijump);
    assign oBranchTarget = iAdderSL2Result;

    assign oValid      = valid_q;
    assign oRegWrite   = reg_write_q;
    assign oMemToReg   = mem_to_reg_q;
    assign oReadData   = read_data_q;
    assign oAluRes     = alu_res_q;
    assign oRegDestMux = rd_q;

endmodule
